// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, the M-extension funct7 value and FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: {hi,lo} is the 2*XLEN shift-add accumulator for multiply
// and {remainder,dividend/quotient} for restoring divide; one step per cycle.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN:0]   add_sum, shifted, diff;

  // hi_next/lo_next are the values after this cycle's step, so the top can
  // form the final result on the same edge that performs the last step.
  always_comb begin
    hi_next = hi_q;
    lo_next = lo_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {add_sum, lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= op_a;
      b_q  <= op_b;
    end else if (step) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: FSM, sign handling and special cases.
// Optional MULDIV_FAST_MUL_EN turns MUL* into single-cycle combinational ops.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic            neg_q;
  logic [4:0]      rd_q;
  logic            accept, bypass, fast_mul;
  logic            a_signed, b_signed, a_neg, b_neg, neg_d, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res, bypass_res;
  logic [XLEN-1:0] hi_next, lo_next;

  function automatic logic [XLEN-1:0] pick(input logic [2:0] f3, input logic neg,
                                           input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   v;
    p = neg ? -{hi, lo} : {hi, lo};
    case (f3)
      F3_MUL:           v = p[XLEN-1:0];
      F3_DIV, F3_DIVU:  v = neg ? -lo : lo;
      F3_REM, F3_REMU:  v = neg ? -hi : hi;
      default:          v = p[2*XLEN-1:XLEN];
    endcase
    return v;
  endfunction

  always_comb begin
    a_signed    = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed    = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
    a_neg       = a_signed & rs1_i[XLEN-1];
    b_neg       = b_signed & rs2_i[XLEN-1];
    abs_a       = a_neg ? -rs1_i : rs1_i;
    abs_b       = b_neg ? -rs2_i : rs2_i;
    // Remainder follows the dividend's sign; everything else the product/quotient sign.
    neg_d       = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = funct3_i[2] && (rs2_i == '0);
    div_ovf     = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                           : (funct3_i[1] ? '0 : MIN_NEG);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = abs_a * abs_b;
  assign fast_mul  = ~funct3_i[2];
  assign fast_res  = pick(funct3_i, neg_d, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`else
  assign fast_mul  = 1'b0;
  assign fast_res  = '0;
`endif

  assign bypass     = div_zero | div_ovf | fast_mul;
  assign bypass_res = fast_mul ? fast_res : special_res;

  // Handshake: an op is taken when start_i=1 and flush_i=0 in IDLE; stall_o holds
  // ID/EX until DONE, where it drops so the same instruction leaves without re-issue.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i && !flush_i) begin
        accept  = 1'b1;
        state_d = bypass ? ST_DONE : ST_CALC;
      end
      ST_CALC: if (flush_i) state_d = ST_IDLE;
               else if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o = ((state_q == ST_IDLE) && start_i && !flush_i) ||
                   ((state_q == ST_CALC) && !flush_i);
  assign done_o  = (state_q == ST_DONE) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q  <= funct3_i;
        neg_q <= neg_d;
        rd_q  <= rd_i;
        cnt_q <= '0;
        if (bypass) begin
          result_o <= bypass_res;
          rd_o     <= rd_i;
        end
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST && !flush_i) begin
          result_o <= pick(f3_q, neg_q, hi_next, lo_next);
          rd_o     <= rd_q;
        end
      end
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .load    (accept),
    .step    (state_q == ST_CALC),
    .is_div  (f3_q[2]),
    .op_a    (abs_a),
    .op_b    (abs_b),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: scoreboarded ops with latency/stall checks,
// special cases, back-to-back issue, flush and mid-op reset.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  rd_exp_q[$];

  always #5 clk_i = ~clk_i;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (f3)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a :
                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Cycles from the start cycle up to and including the done cycle.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return 34;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the instruction has left EX.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int cyc, stalls, exp_cyc;
    bit seen;
    logic [31:0] er;
    logic [4:0]  erd;
    exp_cyc = model_lat(f3, a, b);
    exp_q.push_back(model(f3, a, b));
    rd_exp_q.push_back(rd);
    funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1; flush_i = 1'b0;
    cyc = 1; stalls = 0; seen = 0;
    #1;
    if (stall_o) stalls++;
    while (!seen && cyc < 80) begin
      @(posedge clk_i); #2;
      cyc++;
      if (stall_o) stalls++;
      if (done_o) begin
        seen = 1;
        er  = exp_q.pop_front();
        erd = rd_exp_q.pop_front();
        compared++;
        if (result_o !== er) begin
          mismatched++;
          $display("FAIL %s result: got %08h want %08h", name, result_o, er);
        end
        compared++;
        if (rd_o !== erd) begin
          mismatched++;
          $display("FAIL %s rd: got %0d want %0d", name, rd_o, erd);
        end
        compared++;
        if (cyc !== exp_cyc) begin
          mismatched++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
        end
        compared++;
        if (stalls !== exp_cyc - 1) begin
          mismatched++;
          $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_cyc - 1);
        end
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: no done_o within %0d cycles", name, cyc);
      void'(exp_q.pop_front());
      void'(rd_exp_q.pop_front());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle_check(input string name, input int n);
    start_i = 1'b0;
    flush_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #2;
      compared++;
      if (done_o !== 1'b0 || stall_o !== 1'b0) begin
        mismatched++;
        $display("FAIL %s idle cycle %0d: done=%b stall=%b want 0/0", name, i, done_o, stall_o);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    #2;
    compared++;
    if ({stall_o, done_o, result_o, rd_o} !== 39'd0) begin
      mismatched++;
      $display("FAIL reset outputs: got s%b d%b r%08h rd%0d want all 0", stall_o, done_o, result_o, rd_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_mul;
    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1);
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2);
    do_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd3);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
  endtask

  task automatic test_div;
    do_op("div", 3'b100, 32'hFFFF_FFEC, 32'd6, 5'd6);
    do_op("rem", 3'b110, 32'hFFFF_FFEC, 32'd6, 5'd7);
    do_op("divu", 3'b101, 32'd100, 32'd7, 5'd8);
  endtask

  task automatic test_special;
    do_op("divu_by0", 3'b101, 32'd5, 32'd0, 5'd10);
    do_op("rem_by0", 3'b110, 32'd5, 32'd0, 5'd11);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    idle_check("special", 2);
  endtask

  task automatic test_back_to_back;
    do_op("b2b_mul", 3'b000, 32'h0001_2345, 32'h0000_0100, 5'd5);
    do_op("b2b_div", 3'b100, 32'hFFFF_FC18, 32'd7, 5'd9);
    idle_check("b2b", 3);
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      do_op("rand", f3, a, b, 5'($urandom_range(1, 31)));
    end
    idle_check("rand", 1);
  endtask

  task automatic test_flush;
    funct3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd14;
    start_i = 1'b1; flush_i = 1'b0;
    @(posedge clk_i); #1;
    repeat (10) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    #1;
    compared++;
    if (stall_o !== 1'b0 || done_o !== 1'b0) begin
      mismatched++;
      $display("FAIL flush comb: stall=%b done=%b want 0/0", stall_o, done_o);
    end
    @(posedge clk_i); #1;
    idle_check("flush", 40);
    do_op("after_flush", 3'b111, 32'd1000, 32'd3, 5'd15);
  endtask

  task automatic test_reset_mid;
    funct3_i = 3'b001; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0; rd_i = 5'd17;
    start_i = 1'b1; flush_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    #1;
    compared++;
    if ({stall_o, done_o, result_o, rd_o} !== 39'd0) begin
      mismatched++;
      $display("FAIL reset_mid outputs: got s%b d%b r%08h rd%0d want all 0", stall_o, done_o, result_o, rd_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle_check("reset_mid", 36);
    do_op("after_reset", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
